iob_msg_responder: RTL and testbench



---
 rtl/iob_msg_responder_if.sv | 20 ++
 rtl/iob_msg_responder.sv | 160 ++++++++++++++++
 tb/tb_iob_msg_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_msg_responder_if.sv
// Byte-level link between the UART receiver/transmitter pair and the message responder.
// Handshake: rx_byte is valid for exactly the cycle rx_ready is high (no backpressure on rx);
// tx_byte is taken on a one-cycle tx_send while tx_busy is low, and must stay stable while tx_busy is high.
interface iob_msg_responder_if;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic [7:0] tx_byte;
  logic       tx_send;
  logic       tx_busy;

  modport master (
    output rx_byte, rx_ready, tx_busy,
    input  tx_byte, tx_send
  );

  modport slave (
    input  rx_byte, rx_ready, tx_busy,
    output tx_byte, tx_send
  );
endinterface

// File: rtl/iob_msg_responder.sv
// Far-end I/O-bus memory responder: decodes W/R request messages from the UART byte stream,
// accesses an internal word memory and serialises the OK/EN response back.
module iob_msg_responder #(
  parameter int         AW      = 10,
  parameter logic [3:0] NB      = 4'd0,
  parameter int         TIMEOUT = 65535
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  iob_msg_responder_if.slave    bus,
  output logic                  busy,
  output logic [7:0]            err_cnt,
  output logic [2:0]            dbg_state
);
  localparam int MEM_WORDS = 1 << AW;
  localparam int TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  localparam logic [7:0] CMD_W  = 8'h82;
  localparam logic [7:0] CMD_R  = 8'h83;
  localparam logic [7:0] RSP_OK = 8'h02;
  localparam logic [7:0] RSP_EN = 8'h01;

  localparam logic [1:0] SENT_CMD = 2'd0;
  localparam logic [1:0] SENT_HI  = 2'd1;
  localparam logic [1:0] SENT_LO  = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARGS    = 3'd1,
    EXEC    = 3'd2,
    TX_CMD  = 3'd3,
    TX_HI   = 3'd4,
    TX_LO   = 3'd5,
    TX_WAIT = 3'd6
  } state_t;

  state_t state, state_nx;

  logic          is_read;
  logic [2:0]    arg_cnt;
  logic [7:0]    a1;
  logic [15:0]   a2, a3, rdata;
  logic [TW-1:0] timer;
  logic          skip;
  logic [1:0]    sent;
  logic          read_ok;
  logic [7:0]    tx_byte_q;
  logic [15:0]   mem [MEM_WORDS];

  logic          is_cmd, last_arg, timeout, nb_match, tx_fire, err_inc, in_tx;
  logic [AW-1:0] addr;
  logic          unused_bits;

  assign addr     = a2[AW-1:0];
  assign nb_match = (a1[3:0] == NB);
  assign is_cmd   = (bus.rx_byte == CMD_W) || (bus.rx_byte == CMD_R);
  assign last_arg = (arg_cnt == (is_read ? 3'd2 : 3'd4));
  assign timeout  = !bus.rx_ready && (timer == TMAX);
  assign in_tx    = (state == TX_CMD) || (state == TX_HI) || (state == TX_LO);
  assign tx_fire  = in_tx && !bus.tx_busy;
  // qb/pn and the address bits above AW are kept in the argument registers but never steer the access
  assign unused_bits = ^{a1[7:4], a2[15:AW]};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.rx_ready && is_cmd) state_nx = ARGS;
      ARGS:    if (bus.rx_ready && last_arg) state_nx = EXEC;
               else if (timeout)            state_nx = IDLE;
      EXEC:    state_nx = TX_CMD;
      TX_CMD, TX_HI, TX_LO:
               if (!bus.tx_busy) state_nx = TX_WAIT;
      TX_WAIT: if (!skip && !bus.tx_busy) begin
                 if (sent == SENT_CMD && read_ok) state_nx = TX_HI;
                 else if (sent == SENT_HI)        state_nx = TX_LO;
                 else                             state_nx = IDLE;
               end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.tx_send = tx_fire;
    bus.tx_byte = tx_byte_q;
    busy        = (state != IDLE);
    dbg_state   = state;
    err_inc     = 1'b0;
    case (state)
      IDLE:    err_inc = bus.rx_ready && !is_cmd;
      ARGS:    err_inc = timeout;
      default: err_inc = bus.rx_ready;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      is_read   <= 1'b0;
      arg_cnt   <= '0;
      a1        <= '0;
      a2        <= '0;
      a3        <= '0;
      timer     <= '0;
      skip      <= 1'b0;
      sent      <= SENT_CMD;
      read_ok   <= 1'b0;
      tx_byte_q <= '0;
      err_cnt   <= '0;
    end else begin
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      case (state)
        IDLE: if (state_nx == ARGS) begin
          is_read <= bus.rx_byte[0];
          arg_cnt <= '0;
          timer   <= '0;
        end
        ARGS: if (bus.rx_ready) begin
          timer   <= '0;
          arg_cnt <= arg_cnt + 3'd1;
          case (arg_cnt)
            3'd0:    a1        <= bus.rx_byte;
            3'd1:    a2[15:8]  <= bus.rx_byte;
            3'd2:    a2[7:0]   <= bus.rx_byte;
            3'd3:    a3[15:8]  <= bus.rx_byte;
            default: a3[7:0]   <= bus.rx_byte;
          endcase
        end else begin
          timer <= timer + 1'b1;
        end
        EXEC: begin
          read_ok   <= is_read && nb_match;
          tx_byte_q <= nb_match ? RSP_OK : RSP_EN;
        end
        TX_CMD, TX_HI, TX_LO: if (tx_fire) begin
          skip <= 1'b1;
          sent <= (state == TX_CMD) ? SENT_CMD : (state == TX_HI) ? SENT_HI : SENT_LO;
        end
        TX_WAIT: begin
          // the cycle right after a pulse is skipped so tx_busy has time to rise
          skip <= 1'b0;
          if (state_nx == TX_HI)      tx_byte_q <= rdata[15:8];
          else if (state_nx == TX_LO) tx_byte_q <= rdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (state == EXEC && nb_match) begin
      if (is_read) rdata     <= mem[addr];
      else         mem[addr] <= a3;
    end
  end
endmodule

// File: tb/tb_iob_msg_responder.sv
// Directed bench for iob_msg_responder: UART-side driver, transmitter model with adjustable
// busy time, and an expected-byte queue checked against the captured tx stream.
module tb_iob_msg_responder;
  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [7:0] err_cnt;
  logic [2:0] dbg_state;

  iob_msg_responder_if bus ();

  iob_msg_responder #(.AW(10), .NB(4'd0), .TIMEOUT(100)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // transmitter model: captures each sent byte, raises tx_busy the next cycle for busy_len cycles
  int         busy_len = 3;
  int         busy_cnt;
  logic [7:0] got_mem [1024];
  int         got_wr;
  int         got_rd = 0;
  int         viol;

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bus.tx_busy <= 1'b0;
      busy_cnt    <= 0;
      got_wr      <= got_wr;
      viol        <= viol;
    end else if (bus.tx_send) begin
      if (bus.tx_busy) viol <= viol + 1;
      got_mem[got_wr] <= bus.tx_byte;
      got_wr      <= got_wr + 1;
      bus.tx_busy <= 1'b1;
      busy_cnt    <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt    <= 0;
      bus.tx_busy <= 1'b0;
    end
  end

  initial begin
    got_wr = 0;
    viol   = 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_sys); #1;
    bus.rx_byte  = b;
    bus.rx_ready = 1'b1;
    @(posedge clk_sys); #1;
    bus.rx_ready = 1'b0;
  endtask

  task automatic send_r(input logic [7:0] a1, input logic [15:0] a2);
    send_byte(8'h83); send_byte(a1); send_byte(a2[15:8]); send_byte(a2[7:0]);
  endtask

  task automatic send_w(input logic [7:0] a1, input logic [15:0] a2, input logic [15:0] a3);
    send_byte(8'h82); send_byte(a1); send_byte(a2[15:8]); send_byte(a2[7:0]);
    send_byte(a3[15:8]); send_byte(a3[7:0]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || bus.tx_busy) && n < budget) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk({tag, "_idle_timeout"}, {31'b0, busy | bus.tx_busy}, 32'd0);
  endtask

  task automatic check_resp(input string tag, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] e;
    exp_q.push_back(b0);
    if (n > 1) exp_q.push_back(b1);
    if (n > 2) exp_q.push_back(b2);
    chk({tag, "_count"}, got_wr - got_rd, n);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_byte"}, {24'b0, got_mem[got_rd % 1024]}, {24'b0, e});
      got_rd++;
    end
    got_rd = got_wr;
  endtask

  task automatic wait_sends(input string tag, input int target, input int budget);
    int n = 0;
    while (got_wr < target && n < budget) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk({tag, "_send_timeout"}, {31'b0, got_wr < target}, 32'd0);
  endtask

  initial begin
    int base;
    rst_n        = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.rx_ready = 1'b0;
    #12;
    chk("rst_tx_send", {31'b0, bus.tx_send}, 32'd0);
    chk("rst_tx_byte", {24'b0, bus.tx_byte}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    chk("rst_state", {29'b0, dbg_state}, 32'd0);
    @(posedge clk_sys); #1;
    rst_n = 1'b1;

    // write with latency check: tx_send two cycles after the last request byte
    send_w(8'h00, 16'h0010, 16'hABCD);
    chk("lat_early", {31'b0, bus.tx_send}, 32'd0);
    @(posedge clk_sys); #1;
    chk("lat_send", {31'b0, bus.tx_send}, 32'd1);
    chk("lat_byte", {24'b0, bus.tx_byte}, 32'h02);
    wait_idle("w1", 200);
    check_resp("w1", 1, 8'h02, 8'h00, 8'h00);

    send_r(8'h00, 16'h0010);
    wait_idle("r1", 200);
    check_resp("r1", 3, 8'h02, 8'hAB, 8'hCD);
    chk("mem_010", {16'b0, dut.mem[16]}, 32'hABCD);

    // block number mismatch: EN only, memory untouched
    send_w(8'h05, 16'h0010, 16'h1234);
    wait_idle("w_nb", 200);
    check_resp("w_nb", 1, 8'h01, 8'h00, 8'h00);
    send_r(8'h30, 16'hFC10);
    wait_idle("r_wrap", 200);
    check_resp("r_wrap", 3, 8'h02, 8'hAB, 8'hCD);
    send_r(8'h01, 16'h0010);
    wait_idle("r_nb", 200);
    check_resp("r_nb", 1, 8'h01, 8'h00, 8'h00);
    chk("err_clean", {24'b0, err_cnt}, 32'd0);

    // garbage resync
    send_byte(8'h55);
    send_byte(8'hFF);
    send_r(8'h00, 16'h0010);
    wait_idle("r_sync", 200);
    check_resp("r_sync", 3, 8'h02, 8'hAB, 8'hCD);
    chk("err_sync", {24'b0, err_cnt}, 32'd2);

    // inter-byte timeout discards the partial message
    send_byte(8'h83);
    send_byte(8'h00);
    repeat (150) @(posedge clk_sys);
    #1;
    chk("to_busy", {31'b0, busy}, 32'd0);
    chk("to_err", {24'b0, err_cnt}, 32'd3);
    send_r(8'h00, 16'h0010);
    wait_idle("r_to", 200);
    check_resp("r_to", 3, 8'h02, 8'hAB, 8'hCD);

    // long gap just under the timeout is still one message
    send_byte(8'h83);
    send_byte(8'h00);
    repeat (90) @(posedge clk_sys);
    send_byte(8'h00);
    send_byte(8'h10);
    wait_idle("r_gap", 200);
    check_resp("r_gap", 3, 8'h02, 8'hAB, 8'hCD);
    chk("gap_err", {24'b0, err_cnt}, 32'd3);

    // backpressure after the first response byte; stray rx byte while responding
    base = got_wr;
    busy_len = 500;
    send_r(8'h00, 16'h0010);
    wait_sends("bp", base + 1, 50);
    busy_len = 3;
    send_byte(8'h83);
    repeat (400) @(posedge clk_sys);
    #1;
    chk("bp_hold", got_wr - base, 32'd1);
    chk("bp_busy", {31'b0, bus.tx_busy}, 32'd1);
    wait_idle("bp", 1000);
    check_resp("bp", 3, 8'h02, 8'hAB, 8'hCD);
    chk("bp_err", {24'b0, err_cnt}, 32'd4);
    chk("bp_viol", viol, 32'd0);

    // reset between the high and low data bytes
    base = got_wr;
    busy_len = 20;
    send_r(8'h00, 16'h0010);
    wait_sends("rst_mid", base + 2, 200);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmid_tx_send", {31'b0, bus.tx_send}, 32'd0);
    chk("rmid_busy", {31'b0, busy}, 32'd0);
    chk("rmid_err", {24'b0, err_cnt}, 32'd0);
    chk("rmid_state", {29'b0, dbg_state}, 32'd0);
    check_resp("rmid_partial", 2, 8'h02, 8'hAB, 8'h00);
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    busy_len = 3;
    send_r(8'h00, 16'h0010);
    wait_idle("r_after_rst", 200);
    check_resp("r_after_rst", 3, 8'h02, 8'hAB, 8'hCD);

    // top address and address wrap
    send_w(8'h00, 16'h03FF, 16'h1234);
    wait_idle("w_top", 200);
    check_resp("w_top", 1, 8'h02, 8'h00, 8'h00);
    send_r(8'h00, 16'hFFFF);
    wait_idle("r_top", 200);
    check_resp("r_top", 3, 8'h02, 8'h12, 8'h34);

    // err_cnt saturation
    for (int i = 0; i < 260; i++) send_byte(8'h55);
    #1;
    chk("err_sat", {24'b0, err_cnt}, 32'd255);
    chk("sat_busy", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed running expected finished");
    $fatal(1, "watchdog");
  end
endmodule
